// File: rtl/bru_pkg.sv
// bru_pkg: shared entry type, FSM states and widths for the branch resolve unit
package bru_pkg;
    localparam int BRU_PC_W = 8;
    localparam int STAT_W   = 16;

    typedef struct packed {
        logic [BRU_PC_W-1:0] pc;
        logic                pred;
        logic [BRU_PC_W-1:0] target;
        logic [BRU_PC_W-1:0] pc_plus1;
    } bru_entry_t;

    typedef enum logic {NORMAL, RECOVER} bru_state_e;
endpackage

// File: rtl/bru_fifo.sv
// bru_fifo: in-order branch tracking queue with wrap-around pointers
//   clk, reset  : clock, asynchronous active-high reset
//   push, din   : enqueue one entry
//   pop         : dequeue the head entry
//   clear       : discard every entry (dominates push/pop)
//   full, empty, count, head : occupancy status and oldest entry
module bru_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  bru_entry_t din,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count,
    output bru_entry_t head
);
    bru_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    // the extra pointer bit separates full (tops differ) from empty (tops equal)
    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= clear ? wr_ptr : wr_ptr + {{AW{1'b0}}, push};
            rd_ptr <= clear ? wr_ptr : rd_ptr + {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk)
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves the oldest predicted branch, redirects on mispredict, trains the BHT
//   inputs : clk, reset (async, active-high), push/push_pc/push_pred/push_target/push_pc_plus1,
//            resolve/resolve_taken/resolve_target
//   outputs: full, count, flush, corrected_pc, upd_valid, upd_index, upd_taken, err_ovf, err_unf
//   BRU_STATS_EN defined: adds saturating stat_branches and stat_mispredicts counters
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int PC_W  = BRU_PC_W,
    parameter int DEPTH = 4,
    parameter int IDX_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [PC_W-1:0]          push_pc,
    input  logic                     push_pred,
    input  logic [PC_W-1:0]          push_target,
    input  logic [PC_W-1:0]          push_pc_plus1,
    input  logic                     resolve,
    input  logic                     resolve_taken,
    input  logic [PC_W-1:0]          resolve_target,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     flush,
    output logic [PC_W-1:0]          corrected_pc,
    output logic                     upd_valid,
    output logic [IDX_W-1:0]         upd_index,
    output logic                     upd_taken,
    output logic                     err_ovf,
    output logic                     err_unf
`ifdef BRU_STATS_EN
    ,
    output logic [STAT_W-1:0]        stat_branches,
    output logic [STAT_W-1:0]        stat_mispredicts
`endif
);
    bru_state_e state, state_nx;
    bru_entry_t head, din;
    logic empty, in_rec, do_res, mis, push_ok, fifo_push;

    assign din = '{pc: push_pc, pred: push_pred, target: push_target, pc_plus1: push_pc_plus1};

    bru_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (do_res && !mis),
        .clear (mis),
        .din   (din),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= NORMAL;
        else       state <= state_nx;
    end

    always_comb state_nx = (state == NORMAL && mis) ? RECOVER : NORMAL;

    always_comb in_rec = state == RECOVER;

    // during RECOVER both ports carry wrong-path traffic and are ignored silently
    assign do_res    = resolve && !empty && !in_rec;
    assign mis       = do_res && ((head.pred != resolve_taken) ||
                       (head.pred && resolve_taken && head.target != resolve_target));
    assign push_ok   = push && !in_rec && !mis;
    assign fifo_push = push_ok && (!full || do_res);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush        <= 1'b0;
            corrected_pc <= '0;
            upd_valid    <= 1'b0;
            upd_index    <= '0;
            upd_taken    <= 1'b0;
            err_ovf      <= 1'b0;
            err_unf      <= 1'b0;
        end else begin
            flush     <= mis;
            upd_valid <= do_res;
            if (do_res) begin
                upd_index <= head.pc[IDX_W-1:0];
                upd_taken <= resolve_taken;
            end
            if (mis) corrected_pc <= resolve_taken ? resolve_target : head.pc_plus1;
            err_ovf <= err_ovf || (push_ok && full && !do_res);
            err_unf <= err_unf || (resolve && empty && !in_rec);
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (do_res && stat_branches != '1) stat_branches <= stat_branches + STAT_W'(1);
            if (mis && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + STAT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random checks of branch_resolve_unit against a queue-level model
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;

    logic       clk = 0, reset = 1;
    logic       push = 0, push_pred = 0, resolve = 0, resolve_taken = 0;
    logic [7:0] push_pc = 0, push_target = 0, push_pc_plus1 = 0, resolve_target = 0;
    logic       full, flush, upd_valid, upd_taken, err_ovf, err_unf;
    logic [2:0] count;
    logic [7:0] corrected_pc;
    logic [5:0] upd_index;
`ifdef BRU_STATS_EN
    logic [15:0] stat_branches, stat_mispredicts;
`endif

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.PC_W(8), .DEPTH(DEPTH), .IDX_W(6)) dut (
        .clk(clk), .reset(reset),
        .push(push), .push_pc(push_pc), .push_pred(push_pred),
        .push_target(push_target), .push_pc_plus1(push_pc_plus1),
        .resolve(resolve), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .full(full), .count(count), .flush(flush), .corrected_pc(corrected_pc),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .err_ovf(err_ovf), .err_unf(err_unf)
`ifdef BRU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    typedef struct {
        int pc;
        bit pred;
        int target;
        int pp1;
    } br_t;

    br_t q[$];
    bit  m_rec, e_flush, e_uv, e_ut, e_ovf, e_unf;
    int  e_cpc, e_idx, n_res, n_mis;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rec = 0; e_flush = 0; e_uv = 0; e_ut = 0; e_ovf = 0; e_unf = 0;
        e_cpc = 0; e_idx = 0; n_res = 0; n_mis = 0;
    endtask

    task automatic compare_all();
        check("count", count, q.size());
        check("full", full, q.size() == DEPTH);
        check("flush", flush, e_flush);
        check("upd_valid", upd_valid, e_uv);
        if (e_uv) begin
            check("upd_index", upd_index, e_idx);
            check("upd_taken", upd_taken, e_ut);
        end
        if (e_flush) check("corrected_pc", corrected_pc, e_cpc);
        check("err_ovf", err_ovf, e_ovf);
        check("err_unf", err_unf, e_unf);
`ifdef BRU_STATS_EN
        check("stat_branches", stat_branches, n_res > 65535 ? 65535 : n_res);
        check("stat_mispredicts", stat_mispredicts, n_mis > 65535 ? 65535 : n_mis);
`endif
    endtask

    // one clock: drive inputs, predict the registered outcome, then compare after the edge
    task automatic step(bit p, int pc, bit pr, int tg, bit r, bit tk, int rt);
        bit  rec, dr, mis, acc;
        br_t h, e;
        push = p; push_pc = 8'(pc); push_pred = pr; push_target = 8'(tg);
        push_pc_plus1 = 8'((pc + 1) % 256);
        resolve = r; resolve_taken = tk; resolve_target = 8'(rt);
        rec = m_rec;
        dr  = r && !rec && q.size() > 0;
        if (dr) h = q[0];
        mis = dr && ((h.pred != tk) || (h.pred && tk && h.target != rt));
        e_uv = dr;
        if (dr) begin
            e_idx = h.pc % 64;
            e_ut  = tk;
            n_res++;
        end
        e_flush = mis;
        if (mis) begin
            e_cpc = tk ? rt : h.pp1;
            n_mis++;
        end
        if (r && !rec && q.size() == 0) e_unf = 1;
        acc = 0;
        if (p && !rec && !mis) begin
            if (q.size() < DEPTH || dr) acc = 1;
            else e_ovf = 1;
        end
        if (mis) q.delete();
        else if (dr) void'(q.pop_front());
        if (acc) begin
            e.pc = pc; e.pred = pr; e.target = tg; e.pp1 = (pc + 1) % 256;
            q.push_back(e);
        end
        m_rec = mis;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_flush", flush, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_err_unf", err_unf, 0);

        // correct prediction
        step(1, 'h10, 1, 'h20, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 'h20);
        check("t2_upd_valid", upd_valid, 1);
        check("t2_upd_index", upd_index, 'h10);
        check("t2_upd_taken", upd_taken, 1);
        check("t2_flush", flush, 0);

        // direction miss, then a wrong-path push during recovery
        step(1, 'h05, 1, 'h40, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("t3_flush", flush, 1);
        check("t3_corrected_pc", corrected_pc, 'h06);
        check("t3_upd_taken", upd_taken, 0);
        step(1, 'h77, 0, 0, 0, 0, 0);
        check("t3_wrong_path_push", count, 0);

        // target miss squashes younger entries
        step(1, 'h2a, 1, 'h30, 0, 0, 0);
        step(1, 'h2b, 0, 0, 0, 0, 0);
        step(1, 'h2c, 1, 'h50, 0, 0, 0);
        check("t4_count3", count, 3);
        step(0, 0, 0, 0, 1, 1, 'h34);
        check("t4_flush", flush, 1);
        check("t4_corrected_pc", corrected_pc, 'h34);
        check("t4_count", count, 0);
        idle();

        // fill to full, overflow, then push+resolve while full to wrap pointers
        for (int i = 0; i < 4; i++) step(1, 'h60 + i, 0, 0, 0, 0, 0);
        check("t5_full", full, 1);
        step(1, 'h70, 0, 0, 0, 0, 0);
        check("t5_err_ovf", err_ovf, 1);
        check("t5_count_after_ovf", count, 4);
        for (int i = 0; i < 5; i++) step(1, 'h80 + i, 0, 0, 1, 0, 0);
        check("t5_count_push_resolve", count, 4);
        check("t5_full_push_resolve", full, 1);

        // asynchronous reset mid-run with three entries queued
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
        step(1, 'h90, 0, 0, 0, 0, 0);
        step(1, 'h91, 0, 0, 0, 0, 0);
        step(1, 'h92, 0, 0, 1, 0, 0);
        check("t1_count_before", count, 3);
        reset = 1;
        #2;
        check("t1_count", count, 0);
        check("t1_flush", flush, 0);
        check("t1_upd_valid", upd_valid, 0);
        check("t1_err_ovf", err_ovf, 0);
        check("t1_err_unf", err_unf, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        idle();

        // resolve on empty queue
        step(0, 0, 0, 0, 1, 1, 0);
        check("unf_flag", err_unf, 1);

        // random traffic, biased towards correct predictions
        for (int n = 0; n < 600; n++) begin
            bit p, pr, r, tk;
            int pc, tg, rt;
            p  = $urandom_range(0, 2) != 0;
            pc = $urandom_range(0, 255);
            pr = $urandom_range(0, 1);
            tg = $urandom_range(0, 255);
            r  = $urandom_range(0, 2) != 0;
            tk = $urandom_range(0, 1);
            rt = $urandom_range(0, 255);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                tk = q[0].pred;
                if (tk && $urandom_range(0, 3) != 0) rt = q[0].target;
            end
            step(p, pc, pr, tg, r, tk, rt);
        end

`ifdef BRU_STATS_EN
        reset = 1;
        #2;
        model_reset();
        @(negedge clk);
        reset = 0;
        for (int n = 0; n < 35000; n++) begin
            step(1, n % 256, 1, 'h20, 0, 0, 0);
            step(1, (n + 1) % 256, 1, 'h40, 1, 1, 'h20);
            step(0, 0, 0, 0, 1, 0, 0);
            idle();
        end
        check("stat_branches_sat", stat_branches, 16'hFFFF);
        check("stat_mispredicts_total", stat_mispredicts, 35000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
